// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - widths, PE state and accumulate helper for the systolic array.
// Defining SYSTOLIC_SAT_EN makes acc_add saturate instead of wrapping.
package systolic_pkg;

   localparam int DATA_W   = 8;
   localparam int WEIGHT_W = 8;
   localparam int ACC_W    = 32;
   localparam int PROD_W   = DATA_W + WEIGHT_W;

`ifdef SYSTOLIC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   typedef struct packed {
      logic signed [WEIGHT_W-1:0] w_inact;
      logic signed [WEIGHT_W-1:0] w_act;
      logic signed [DATA_W-1:0]   data_reg;
      logic                       valid_reg;
      logic                       switch_reg;
      logic signed [ACC_W-1:0]    psum_reg;
      logic                       psum_valid_reg;
   } pe_state_t;

   // One guard bit above the accumulator exposes signed overflow.
   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0]  acc,
                                                       input logic signed [PROD_W-1:0] prod);
      logic signed [ACC_W:0] sum;
      sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
`ifdef SYSTOLIC_SAT_EN
      if (sum[ACC_W] != sum[ACC_W-1])
         return sum[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
      return sum[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/systolic_array_if.sv
// rtl/systolic_array_if.sv - activation, weight, switch, column-size and result bundle of the array.
interface systolic_array_if #(
   parameter int N = 2
);
   import systolic_pkg::*;

   logic signed [DATA_W-1:0]   sys_data_in   [N];
   logic [N-1:0]               sys_valid_in;
   logic signed [WEIGHT_W-1:0] sys_weight_in [N];
   logic [N-1:0]               sys_accept_w;
   logic [N-1:0]               sys_switch_in;
   logic [15:0]                ub_rd_col_size_in;
   logic                       ub_rd_col_size_valid_in;
   logic signed [ACC_W-1:0]    sys_data_out  [N];
   logic [N-1:0]               sys_valid_out;

   modport master (
      output sys_data_in, sys_valid_in, sys_weight_in, sys_accept_w, sys_switch_in,
      output ub_rd_col_size_in, ub_rd_col_size_valid_in,
      input  sys_data_out, sys_valid_out
   );

   modport slave (
      input  sys_data_in, sys_valid_in, sys_weight_in, sys_accept_w, sys_switch_in,
      input  ub_rd_col_size_in, ub_rd_col_size_valid_in,
      output sys_data_out, sys_valid_out
   );

endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - weight-stationary int8 MAC cell with shadow weight and switch forwarding.
module systolic_pe
   import systolic_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       col_en,
   input  logic                       accept_w,
   input  logic signed [WEIGHT_W-1:0] weight_north,
   input  logic signed [DATA_W-1:0]   data_west,
   input  logic                       valid_west,
   input  logic                       switch_west,
   input  logic signed [ACC_W-1:0]    psum_north,
   output logic signed [WEIGHT_W-1:0] weight_south,
   output logic signed [DATA_W-1:0]   data_east,
   output logic                       valid_east,
   output logic                       switch_east,
   output logic signed [ACC_W-1:0]    psum_south,
   output logic                       psum_valid_south
);

   pe_state_t                 st;
   logic signed [PROD_W-1:0]  prod;

   assign prod = PROD_W'(data_west) * PROD_W'(st.w_act);

   // w_act copies the pre-edge w_inact, so a same-cycle weight shift lands in the shadow only.
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= '0;
      end else begin
         if (accept_w)
            st.w_inact <= weight_north;
         if (switch_west)
            st.w_act <= st.w_inact;
         st.data_reg   <= data_west;
         st.valid_reg  <= valid_west;
         st.switch_reg <= switch_west;
         if (valid_west && col_en) begin
            st.psum_reg       <= acc_add(psum_north, prod);
            st.psum_valid_reg <= 1'b1;
         end else begin
            st.psum_reg       <= '0;
            st.psum_valid_reg <= 1'b0;
         end
      end
   end

   assign weight_south     = st.w_inact;
   assign data_east        = st.data_reg;
   assign valid_east       = st.valid_reg;
   assign switch_east      = st.switch_reg;
   assign psum_south       = st.psum_reg;
   assign psum_valid_south = st.psum_valid_reg;

endmodule

// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - N x N weight-stationary systolic array: column-size register and PE mesh.
module systolic_array
   import systolic_pkg::*;
#(
   parameter int SYSTOLIC_ARRAY_WIDTH = 2
) (
   input logic              clk,
   input logic              rst,
   systolic_array_if.slave  sys
);

   localparam int N = SYSTOLIC_ARRAY_WIDTH;

   logic [15:0]                col_size;
   logic [N-1:0]               col_en;

   logic signed [WEIGHT_W-1:0] weight_s     [N][N];
   logic signed [DATA_W-1:0]   data_e       [N][N];
   logic                       valid_e      [N][N];
   logic                       switch_e     [N][N];
   logic signed [ACC_W-1:0]    psum_s       [N][N];
   logic                       psum_valid_s [N][N];

   always_ff @(posedge clk) begin
      if (rst)
         col_size <= '0;
      else if (sys.ub_rd_col_size_valid_in)
         col_size <= sys.ub_rd_col_size_in;
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         logic signed [WEIGHT_W-1:0] weight_n;
         logic signed [DATA_W-1:0]   data_w;
         logic                       valid_w;
         logic                       switch_w;
         logic signed [ACC_W-1:0]    psum_n;

         if (c == 0) begin : g_west
            assign data_w   = sys.sys_data_in[r];
            assign valid_w  = sys.sys_valid_in[r];
            assign switch_w = sys.sys_switch_in[r];
         end else begin : g_inner_w
            assign data_w   = data_e[r][c-1];
            assign valid_w  = valid_e[r][c-1];
            assign switch_w = switch_e[r][c-1];
         end

         if (r == 0) begin : g_north
            assign weight_n = sys.sys_weight_in[c];
            assign psum_n   = '0;
         end else begin : g_inner_n
            assign weight_n = weight_s[r-1][c];
            assign psum_n   = psum_s[r-1][c];
         end

         systolic_pe u_pe (
            .clk              (clk),
            .rst              (rst),
            .col_en           (col_en[c]),
            .accept_w         (sys.sys_accept_w[c]),
            .weight_north     (weight_n),
            .data_west        (data_w),
            .valid_west       (valid_w),
            .switch_west      (switch_w),
            .psum_north       (psum_n),
            .weight_south     (weight_s[r][c]),
            .data_east        (data_e[r][c]),
            .valid_east       (valid_e[r][c]),
            .switch_east      (switch_e[r][c]),
            .psum_south       (psum_s[r][c]),
            .psum_valid_south (psum_valid_s[r][c])
         );
      end
   end

   // Sizes above N simply enable every column.
   for (genvar c = 0; c < N; c++) begin : g_out
      assign col_en[c]            = col_size > 16'(c);
      assign sys.sys_data_out[c]  = psum_s[N-1][c];
      assign sys.sys_valid_out[c] = psum_valid_s[N-1][c];
   end

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - directed self-checking bench for the 2x2 systolic array.
module tb_systolic_array;
   import systolic_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   systolic_array_if #(.N(2)) sys ();

   systolic_array #(.SYSTOLIC_ARRAY_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .sys (sys)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int c = 0; c < 2; c++) begin
         sys.sys_data_in[c]   = '0;
         sys.sys_weight_in[c] = '0;
      end
      sys.sys_valid_in            = '0;
      sys.sys_accept_w            = '0;
      sys.sys_switch_in           = '0;
      sys.ub_rd_col_size_in       = '0;
      sys.ub_rd_col_size_valid_in = 1'b0;
   endtask

   task automatic set_col_size(input int v);
      sys.ub_rd_col_size_in       = 16'(v);
      sys.ub_rd_col_size_valid_in = 1'b1;
      step();
      sys.ub_rd_col_size_valid_in = 1'b0;
   endtask

   task automatic stream(input logic signed [7:0] d0, input logic signed [7:0] d1, input logic [1:0] v);
      sys.sys_data_in[0] = d0;
      sys.sys_data_in[1] = d1;
      sys.sys_valid_in   = v;
   endtask

   // Bottom row is shifted in first; switch both rows together.
   task automatic load_and_switch(input logic signed [7:0] w00, input logic signed [7:0] w01,
                                  input logic signed [7:0] w10, input logic signed [7:0] w11);
      sys.sys_accept_w     = 2'b11;
      sys.sys_weight_in[0] = w10;
      sys.sys_weight_in[1] = w11;
      step();
      sys.sys_weight_in[0] = w00;
      sys.sys_weight_in[1] = w01;
      step();
      sys.sys_accept_w  = 2'b00;
      sys.sys_switch_in = 2'b11;
      step();
      sys.sys_switch_in = 2'b00;
      step();
   endtask

   // A = [[10,1],[20,2]] fed skewed: row 0 from step 0, row 1 from step 1.
   task automatic matrix_step(input int i);
      case (i)
         0:       stream(8'sd10, 8'sd0, 2'b01);
         1:       stream(8'sd20, 8'sd1, 2'b11);
         2:       stream(8'sd0,  8'sd2, 2'b10);
         default: stream(8'sd0,  8'sd0, 2'b00);
      endcase
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (sys.sys_data_out[c] !== 32'sd0 || sys.sys_valid_out[c] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out col %0d: got %0d/%0b expected 0/0", c, sys.sys_data_out[c], sys.sys_valid_out[c]);
         end
      end
      rst = 1'b0;
      stream(8'sd7, 8'sd3, 2'b11);
      for (int i = 0; i < 3; i++) begin
         step();
         for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (sys.sys_data_out[c] !== 32'sd0 || sys.sys_valid_out[c] !== 1'b0) begin
               n_fail++;
               $display("FAIL no_col_size step %0d col %0d: got %0d/%0b expected 0/0", i, c, sys.sys_data_out[c], sys.sys_valid_out[c]);
            end
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_weight_compute();
      int   e0 [5] = '{0, 24, 48, 0, 0};
      int   e1 [5] = '{0, 0, 35, 70, 0};
      logic v0 [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic v1 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      set_col_size(2);
      load_and_switch(8'sd2, 8'sd3, 8'sd4, 8'sd5);
      for (int i = 0; i < 5; i++) begin
         matrix_step(i);
         step();
         n_checks++;
         if (sys.sys_data_out[0] !== 32'(e0[i]) || sys.sys_valid_out[0] !== v0[i]) begin
            n_fail++;
            $display("FAIL mm_col0 step %0d: got %0d/%0b expected %0d/%0b", i, sys.sys_data_out[0], sys.sys_valid_out[0], e0[i], v0[i]);
         end
         n_checks++;
         if (sys.sys_data_out[1] !== 32'(e1[i]) || sys.sys_valid_out[1] !== v1[i]) begin
            n_fail++;
            $display("FAIL mm_col1 step %0d: got %0d/%0b expected %0d/%0b", i, sys.sys_data_out[1], sys.sys_valid_out[1], e1[i], v1[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_col_enable();
      int   e0 [5] = '{0, 24, 48, 0, 0};
      logic v0 [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      set_col_size(1);
      for (int i = 0; i < 5; i++) begin
         matrix_step(i);
         step();
         n_checks++;
         if (sys.sys_data_out[0] !== 32'(e0[i]) || sys.sys_valid_out[0] !== v0[i]) begin
            n_fail++;
            $display("FAIL colen_col0 step %0d: got %0d/%0b expected %0d/%0b", i, sys.sys_data_out[0], sys.sys_valid_out[0], e0[i], v0[i]);
         end
         n_checks++;
         if (sys.sys_data_out[1] !== 32'sd0 || sys.sys_valid_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL colen_col1 step %0d: got %0d/%0b expected 0/0", i, sys.sys_data_out[1], sys.sys_valid_out[1]);
         end
      end
      idle_inputs();
   endtask

   // Active W=[[2,3],[4,5]], shadow W=[[1,2],[3,3]], all-ones activations.
   task automatic test_switch_midstream();
      int e0 [5] = '{6, 6, 5, 4, 4};
      int e1 [5] = '{8, 8, 8, 6, 5};
      set_col_size(2);
      stream(8'sd1, 8'sd1, 2'b11);
      sys.sys_accept_w     = 2'b11;
      sys.sys_weight_in[0] = 8'sd3;
      sys.sys_weight_in[1] = 8'sd3;
      step();
      sys.sys_weight_in[0] = 8'sd1;
      sys.sys_weight_in[1] = 8'sd2;
      step();
      sys.sys_accept_w = 2'b00;
      for (int i = 0; i < 5; i++) begin
         sys.sys_switch_in = (i == 1) ? 2'b11 : 2'b00;
         step();
         n_checks++;
         if (sys.sys_data_out[0] !== 32'(e0[i]) || sys.sys_valid_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_col0 step %0d: got %0d/%0b expected %0d/1", i, sys.sys_data_out[0], sys.sys_valid_out[0], e0[i]);
         end
         n_checks++;
         if (sys.sys_data_out[1] !== 32'(e1[i]) || sys.sys_valid_out[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_col1 step %0d: got %0d/%0b expected %0d/1", i, sys.sys_data_out[1], sys.sys_valid_out[1], e1[i]);
         end
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_overflow();
      logic signed [31:0] r;
      logic signed [31:0] exp_hi;
      logic signed [31:0] exp_lo;
`ifdef SYSTOLIC_SAT_EN
      exp_hi = 32'sh7FFF_FFFF;
      exp_lo = 32'sh8000_0000;
`else
      exp_hi = 32'sh8000_0000;
      exp_lo = 32'sh7FFF_FFFF;
`endif
      load_and_switch(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
      stream(-8'sd128, -8'sd128, 2'b11);
      step();
      step();
      step();
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (sys.sys_data_out[c] !== 32'sd32768 || sys.sys_valid_out[c] !== 1'b1) begin
            n_fail++;
            $display("FAIL min_product col %0d: got %0d/%0b expected 32768/1", c, sys.sys_data_out[c], sys.sys_valid_out[c]);
         end
      end
      r = acc_add(32'sh7FFF_C000, 16'sh4000);
      n_checks++;
      if (r !== exp_hi) begin
         n_fail++;
         $display("FAIL acc_pos_overflow: got %h expected %h", r, exp_hi);
      end
      r = acc_add(32'sh8000_0000, 16'shFFFF);
      n_checks++;
      if (r !== exp_lo) begin
         n_fail++;
         $display("FAIL acc_neg_overflow: got %h expected %h", r, exp_lo);
      end
      r = acc_add(32'sd100, 16'shFF9C);
      n_checks++;
      if (r !== 32'sd0) begin
         n_fail++;
         $display("FAIL acc_plain_add: got %0d expected 0", r);
      end
   endtask

   // Streaming all-ones with W=-128 everywhere, then reset and restart without loading weights.
   task automatic test_reset_midstream();
      stream(8'sd1, 8'sd1, 2'b11);
      step();
      step();
      n_checks++;
      if (sys.sys_data_out[0] !== -32'sd256 || sys.sys_valid_out[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset col0: got %0d/%0b expected -256/1", sys.sys_data_out[0], sys.sys_valid_out[0]);
      end
      rst = 1'b1;
      step();
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (sys.sys_data_out[c] !== 32'sd0 || sys.sys_valid_out[c] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset col %0d: got %0d/%0b expected 0/0", c, sys.sys_data_out[c], sys.sys_valid_out[c]);
         end
      end
      rst = 1'b0;
      idle_inputs();
      set_col_size(2);
      sys.sys_switch_in = 2'b11;
      stream(8'sd1, 8'sd1, 2'b11);
      step();
      sys.sys_switch_in = 2'b00;
      step();
      step();
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (sys.sys_data_out[c] !== 32'sd0 || sys.sys_valid_out[c] !== 1'b1) begin
            n_fail++;
            $display("FAIL weights_cleared col %0d: got %0d/%0b expected 0/1", c, sys.sys_data_out[c], sys.sys_valid_out[c]);
         end
      end
      idle_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_weight_compute();
      test_col_enable();
      test_switch_midstream();
      test_overflow();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_array.md
# systolic_array

Weight-stationary N×N systolic array of int8 multiply-accumulate processing elements (PEs); this is the compute core of the tensor-core datapath. Activations enter on the west edge and flow east. Weights are shifted in from the north into shadow (inactive) registers and made active by a west-to-east switch wave. Partial sums flow north to south and leave the south edge as 32-bit column results.

## Interface
Parameters:
- SYSTOLIC_ARRAY_WIDTH, default 2: N, the number of rows and columns; must be ≥ 1.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sys_data_in  in  [N] × signed 8  west activation, one per row.
- sys_valid_in  in  [N] × 1  west activation valid, one per row.
- sys_weight_in  in  [N] × signed 8  north weight, one per column.
- sys_accept_w  in  [N] × 1  per-column weight shift enable.
- sys_switch_in  in  [N] × 1  per-row switch pulse, entering PE(r,0).
- ub_rd_col_size_in  in  16  number of enabled columns.
- ub_rd_col_size_valid_in  in  1  load strobe for ub_rd_col_size_in.
- sys_data_out  out  [N] × signed 32  south partial sum, one per column.
- sys_valid_out  out  [N] × 1  south valid, one per column.

## Operation
- Each PE(r,c) holds: w_inact, w_act, data_reg, valid_reg, switch_reg, psum_reg and psum_valid_reg.
- Weight load: when sys_accept_w[c]=1, PE(0,c).w_inact ← sys_weight_in[c], and PE(r,c).w_inact ← PE(r-1,c).w_inact for r > 0. Loading the bottom row's weight first therefore fills a column in N cycles.
- Switch: PE(r,0) samples sys_switch_in[r]; PE(r,c) samples PE(r,c-1).switch_reg. When the sampled switch value is 1, w_act ← w_inact.
  - If switch and accept_w occur in the same cycle, w_act takes the pre-edge w_inact.
- Data: data_reg and valid_reg are forwarded east one column per cycle. Disabled columns still forward data.
- Compute: psum_reg ← psum_in + data_in × w_act when valid_in=1 and the column is enabled; otherwise psum_reg ← 0.
  - psum_valid_reg ← valid_in AND column enabled.
  - Row 0 has psum_in = 0.
  - sys_data_out[c] and sys_valid_out[c] are taken from PE(N-1,c).
- Arithmetic: 8×8 signed product (16 bit), sign-extended to 32 bit; the add wraps modulo 2^32 unless SYSTOLIC_SAT_EN is defined.
- Column enable: a col_size register loads on ub_rd_col_size_valid_in. Column c is enabled iff c < col_size; values > N enable all columns.
- Alignment is the caller's job: row r is fed skewed by r cycles, with row r carrying reduction index k=r and W[r][c] held in PE(r,c).

## Timing
- Reset: every register, including col_size, is cleared to 0, so all columns are disabled. All outputs read 0 the cycle after reset. Reset applied mid-operation discards all in-flight data and all weights.
- Latency: an activation sampled at row 0 on edge k produces output row m of column c after edge k + m + (N−1) + c.
- Throughput is one result per column per cycle.
- A col_size update takes effect on the next edge, including for data already in flight.
- The switch wave reaches column c c cycles after entry. New weights must finish loading before the switch pulse arrives.

## Configuration
- SYSTOLIC_SAT_EN defined: each accumulate saturates to [−2^31, 2^31−1].
- SYSTOLIC_SAT_EN undefined: two's-complement wrap.

## Structure
- systolic_pkg holds DATA_W=8, WEIGHT_W=8, ACC_W=32 and the PE state typedef.
- One sub-module, systolic_pe, is instantiated N×N through a generate loop. The array level adds only col_size and the wiring.

## Test plan
- Reset -> all sys_data_out = 0 and sys_valid_out = 0; with no col_size load, valid inputs still produce 0 and valid_out = 0.
- N=2 weight load and compute:
  - Stimulus: col_size=2; accept_w with [4,5] then [2,3]; switch pulse on both rows. Row 0 feeds A[·][0]=10,20 starting at edge k; row 1 feeds A[·][1]=1,2 starting at edge k+1.
  - Required response: col0 = 24 after edge k+1 and 48 after edge k+2; col1 = 35 after edge k+2 and 70 after edge k+3; valid high exactly on those cycles; afterwards 0.
- Column enable: col_size=1, same stimulus -> col1 stays 0 with valid 0; col0 unchanged.
- Switch mid-stream: load new weights into w_inact during compute -> results are unchanged until the switch wave arrives, and then use the new weights column by column.
- Overflow: weights and data of −128 with N large enough, or a preset wrap case:
  - Without SYSTOLIC_SAT_EN -> wrapped value.
  - With SYSTOLIC_SAT_EN -> clamps at 2^31−1.
- Reset asserted mid-compute -> outputs are 0 the next cycle; all weights are cleared.
